// File: rtl/seq_pkg.sv
// seq_pkg: constants shared by the serial word feeder and the sequence detectors.
package seq_pkg;
  localparam logic ST_IDLE  = 1'b0;
  localparam logic ST_SHIFT = 1'b1;
  localparam logic [3:0] PAT_1101 = 4'b1101;
endpackage

// File: rtl/serial_word_feeder_if.sv
// serial_word_feeder_if: parallel word handshake in, serial bit stream out.
interface serial_word_feeder_if #(parameter int WIDTH = 8);
  logic [WIDTH-1:0] data_in;
  logic             data_valid;
  logic             data_ready;
  logic             ser_out;
  logic             ser_valid;
  logic             frame_done;
  modport master (output data_in, data_valid, input data_ready, ser_out, ser_valid, frame_done);
  modport slave  (input data_in, data_valid, output data_ready, ser_out, ser_valid, frame_done);
endinterface

// File: rtl/serial_word_feeder.sv
// serial_word_feeder: takes WIDTH-bit words on valid/ready and emits them one bit per clock, gapless between words.
module serial_word_feeder
  import seq_pkg::*;
#(
  parameter int WIDTH      = 8,
  parameter bit MSB_FIRST  = 1,
  parameter bit IDLE_LEVEL = 0
) (
  input logic clk,
  input logic rst,
  serial_word_feeder_if.slave bus
);
  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);
  logic             state, state_nx;
  logic [WIDTH-1:0] shift_reg;
  logic [CW-1:0]    bit_cnt;
  logic             ready, last, accept;
  assign last   = (state == ST_SHIFT) && (bit_cnt == LAST);
  assign accept = bus.data_valid & ready;
  assign bus.data_ready = ready;
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      state          <= ST_IDLE;
      shift_reg      <= '0;
      bit_cnt        <= '0;
      bus.ser_out    <= IDLE_LEVEL;
      bus.ser_valid  <= 1'b0;
      bus.frame_done <= 1'b0;
    end else begin
      state <= state_nx;
      if (accept) begin
        shift_reg      <= bus.data_in;
        bus.ser_out    <= MSB_FIRST ? bus.data_in[WIDTH-1] : bus.data_in[0];
        bus.ser_valid  <= 1'b1;
        bit_cnt        <= '0;
        bus.frame_done <= 1'b0;
      end else if (state == ST_SHIFT && !last) begin
        // the next bit to send is the neighbour of the one currently on ser_out
        shift_reg      <= MSB_FIRST ? shift_reg << 1 : shift_reg >> 1;
        bus.ser_out    <= MSB_FIRST ? shift_reg[WIDTH-2] : shift_reg[1];
        bit_cnt        <= bit_cnt + CW'(1);
        bus.frame_done <= (bit_cnt + CW'(1)) == LAST;
      end else begin
        bus.ser_out    <= IDLE_LEVEL;
        bus.ser_valid  <= 1'b0;
        bit_cnt        <= '0;
        bus.frame_done <= 1'b0;
      end
    end
  always_comb state_nx = accept ? ST_SHIFT : (state == ST_SHIFT && !last) ? ST_SHIFT : ST_IDLE;
  always_comb ready = (state == ST_IDLE) | last;
endmodule

// File: tb/tb_serial_word_feeder.sv
// tb_serial_word_feeder: random and directed stimulus against a bit-queue model of the feeder.
module tb_serial_word_feeder;
  logic clk = 1'b0;
  logic rst;
  logic [7:0] din;
  logic dv;
  int checks = 0;
  int errors = 0;
  bit qa[$];
  bit qb[$];
  serial_word_feeder_if #(.WIDTH(8)) ia ();
  serial_word_feeder_if #(.WIDTH(8)) ib ();
  assign ia.data_in = din;
  assign ia.data_valid = dv;
  assign ib.data_in = din;
  assign ib.data_valid = dv;
  serial_word_feeder #(.WIDTH(8), .MSB_FIRST(1), .IDLE_LEVEL(0)) dut_a (.clk(clk), .rst(rst), .bus(ia));
  serial_word_feeder #(.WIDTH(8), .MSB_FIRST(0), .IDLE_LEVEL(1)) dut_b (.clk(clk), .rst(rst), .bus(ib));
  always #5 clk = ~clk;
  task automatic chk(input string n, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %0h want %0h", n, act, exp);
    end
  endtask
  // model: queue holds the bit now on ser_out followed by the bits still to come
  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      qa.delete();
      qb.delete();
    end else begin
      bit ra, rb;
      ra = qa.size() <= 1;
      rb = qb.size() <= 1;
      if (qa.size() > 0) void'(qa.pop_front());
      if (qb.size() > 0) void'(qb.pop_front());
      if (dv && ra) for (int i = 7; i >= 0; i--) qa.push_back(din[i]);
      if (dv && rb) for (int i = 0; i < 8; i++) qb.push_back(din[i]);
    end
  end
  always @(negedge clk) begin
    chk("a_valid", 32'(ia.ser_valid), 32'(qa.size() != 0));
    chk("a_out", 32'(ia.ser_out), 32'(qa.size() != 0 ? qa[0] : 1'b0));
    chk("a_frame", 32'(ia.frame_done), 32'(qa.size() == 1));
    chk("a_ready", 32'(ia.data_ready), 32'(qa.size() <= 1));
    chk("b_valid", 32'(ib.ser_valid), 32'(qb.size() != 0));
    chk("b_out", 32'(ib.ser_out), 32'(qb.size() != 0 ? qb[0] : 1'b1));
    chk("b_frame", 32'(ib.frame_done), 32'(qb.size() == 1));
    chk("b_ready", 32'(ib.data_ready), 32'(qb.size() <= 1));
  end
  initial begin
    logic [7:0]  bits_a, bits_b, fd;
    logic [15:0] str;
    logic [16:0] rdy;
    int vcnt;
    din = '0;
    dv  = 1'b0;
    rst = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_valid", 32'(ia.ser_valid), 0);
    chk("rst_out", 32'(ia.ser_out), 0);
    chk("rst_frame", 32'(ia.frame_done), 0);
    chk("rst_ready", 32'(ia.data_ready), 1);
    chk("rst_b_out", 32'(ib.ser_out), 1);
    rst = 1'b1;
    repeat (2) @(negedge clk);
    // single word 0xDD
    din = 8'hDD;
    dv  = 1'b1;
    @(negedge clk);
    dv = 1'b0;
    vcnt = 0;
    for (int i = 0; i < 8; i++) begin
      bits_a[7-i] = ia.ser_out;
      fd[7-i] = ia.frame_done;
      vcnt += int'(ia.ser_valid);
      @(negedge clk);
    end
    chk("t1_bits", 32'(bits_a), 32'h DD);
    chk("t1_frame", 32'(fd), 32'h01);
    chk("t1_valid", 32'(vcnt), 8);
    chk("t1_idle_after", 32'(ia.ser_valid), 0);
    repeat (2) @(negedge clk);
    // back-to-back 0xD0, 0x0D with valid held
    din = 8'hD0;
    dv  = 1'b1;
    vcnt = 0;
    str = '0;
    for (int i = 0; i < 17; i++) begin
      rdy[i] = ia.data_ready;
      if (i > 0) begin
        str = {str[14:0], ia.ser_out};
        vcnt += int'(ia.ser_valid);
      end
      if (i == 1) din = 8'h0D;
      if (i == 16) dv = 1'b0;
      @(negedge clk);
    end
    chk("t2_stream", 32'(str), 32'h D00D);
    chk("t2_valid", 32'(vcnt), 16);
    chk("t2_ready", 32'(rdy), 32'h10101);
    repeat (2) @(negedge clk);
    // LSB-first instance with 0xB0
    din = 8'hB0;
    dv  = 1'b1;
    @(negedge clk);
    dv = 1'b0;
    for (int i = 0; i < 8; i++) begin
      bits_b[7-i] = ib.ser_out;
      fd[7-i] = ib.frame_done;
      @(negedge clk);
    end
    chk("t3_bits", 32'(bits_b), 32'h0D);
    chk("t3_frame", 32'(fd), 32'h01);
    repeat (2) @(negedge clk);
    // 0xFF offered mid-word must be ignored
    din = 8'hDD;
    dv  = 1'b1;
    @(negedge clk);
    dv = 1'b0;
    for (int i = 0; i < 8; i++) begin
      bits_a[7-i] = ia.ser_out;
      if (i == 3) begin
        din = 8'hFF;
        dv  = 1'b1;
        chk("t4_ready", 32'(ia.data_ready), 0);
      end
      if (i == 4) dv = 1'b0;
      @(negedge clk);
    end
    chk("t4_bits", 32'(bits_a), 32'h DD);
    chk("t4_no_extra", 32'(ia.ser_valid), 0);
    repeat (2) @(negedge clk);
    // asynchronous reset at bit_cnt 4
    din = 8'hDD;
    dv  = 1'b1;
    @(negedge clk);
    dv = 1'b0;
    repeat (4) @(negedge clk);
    #2 rst = 1'b0;
    #1;
    chk("t5_valid", 32'(ia.ser_valid), 0);
    chk("t5_out", 32'(ia.ser_out), 0);
    chk("t5_b_out", 32'(ib.ser_out), 1);
    @(negedge clk);
    rst = 1'b1;
    vcnt = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      vcnt += int'(ia.ser_valid) + int'(ib.ser_valid);
    end
    chk("t5_residual", 32'(vcnt), 0);
    chk("t5_ready", 32'(ia.data_ready), 1);
    // 20 idle cycles
    vcnt = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      vcnt += int'(ia.ser_valid) + int'(ia.ser_out) + int'(ia.frame_done);
    end
    chk("t6_idle", 32'(vcnt), 0);
    // random traffic with occasional short asynchronous resets
    for (int k = 0; k < 3000; k++) begin
      @(negedge clk);
      dv  = ($urandom_range(0, 3) != 0);
      din = 8'($urandom);
      if ($urandom_range(0, 199) == 0) begin
        #2 rst = 1'b0;
        #2 rst = 1'b1;
      end
    end
    @(negedge clk);
    dv = 1'b0;
    repeat (12) @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
